// File: rtl/alu_display_seq.sv
// alu_display_seq
//   Two-stage registered ALU with a time-multiplexed hex display.
//   Stage 1 captures operands and opcode on start; stage 2 registers the
//   result and N/Z/C/V flags and pulses valid. A refresh counter scans the
//   display one hex digit at a time.
//
// Ports
//   clk        single clock, rising edge
//   rst_n      synchronous active-low reset
//   a, b       operands (WIDTH bits)
//   sel        operation select (4 bits)
//   start      capture a/b/sel this cycle
//   disp_sel   display source: 0 result, 1 captured a, 2 captured b, 3 flags
//   result     registered ALU result
//   negative, zero, carryF, oVerflow   registered N/Z/C/V flags
//   valid      one-cycle pulse when result/flags update
//   segments   active-low {g,f,e,d,c,b,a} of the lit digit
//   anodes     active-low digit enables, one low at a time
module alu_display_seq #(
    parameter int WIDTH       = 8,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [3:0]           sel,
    input  logic                 start,
    input  logic [1:0]           disp_sel,
    output logic [WIDTH-1:0]     result,
    output logic                 negative,
    output logic                 zero,
    output logic                 carryF,
    output logic                 oVerflow,
    output logic                 valid,
    output logic [6:0]           segments,
    output logic [WIDTH/4-1:0]   anodes
);

    localparam int DIGITS = WIDTH / 4;
    localparam int SW     = $clog2(WIDTH);
    localparam int CW     = $clog2(REFRESH_DIV);
    localparam int IW     = $clog2(DIGITS);
    localparam int MSB    = WIDTH - 1;

    logic [WIDTH-1:0] op_a, op_b;
    logic [3:0]       op_sel;
    logic             s1_valid;
    logic [CW-1:0]    refresh_cnt;
    logic [IW-1:0]    digit_idx;

    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shl_ext;
    logic [WIDTH:0]   shr_ext;
    logic [SW-1:0]    amt;

    logic [WIDTH-1:0] disp_src;
    logic [3:0]       nibble;

    always_comb begin
        amt     = op_b[SW-1:0];
        // One guard bit beyond the operand: after the shift it holds the
        // last bit pushed out (and stays 0 for a zero shift amount).
        shl_ext = {1'b0, op_a} << amt;
        shr_ext = {op_a, 1'b0} >> amt;
        sum     = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_sel)
            4'b0000: begin
                sum     = {1'b0, op_a} + {1'b0, op_b};
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (op_a[MSB] == op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
            end
            4'b0001: begin
                sum     = {1'b0, op_a} + {1'b0, ~op_b} + (WIDTH+1)'(1);
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (op_a[MSB] != op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
            end
            4'b0010: alu_res = op_a & op_b;
            4'b0011: alu_res = op_a | op_b;
            4'b0100: alu_res = op_a ^ op_b;
            4'b0101: alu_res = ~op_a;
            4'b0110: begin
                alu_res = shl_ext[WIDTH-1:0];
                alu_c   = shl_ext[WIDTH];
            end
            4'b0111: begin
                alu_res = shr_ext[WIDTH:1];
                alu_c   = shr_ext[0];
            end
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a        <= '0;
            op_b        <= '0;
            op_sel      <= '0;
            s1_valid    <= 1'b0;
            result      <= '0;
            negative    <= 1'b0;
            zero        <= 1'b0;
            carryF      <= 1'b0;
            oVerflow    <= 1'b0;
            valid       <= 1'b0;
            refresh_cnt <= '0;
            digit_idx   <= '0;
        end else begin
            s1_valid <= start;
            if (start) begin
                op_a   <= a;
                op_b   <= b;
                op_sel <= sel;
            end

            valid <= s1_valid;
            if (s1_valid) begin
                result   <= alu_res;
                negative <= alu_res[MSB];
                zero     <= (alu_res == '0);
                carryF   <= alu_c;
                oVerflow <= alu_v;
            end

            if (refresh_cnt == CW'(REFRESH_DIV - 1)) begin
                refresh_cnt <= '0;
                if (digit_idx == IW'(DIGITS - 1))
                    digit_idx <= '0;
                else
                    digit_idx <= digit_idx + IW'(1);
            end else begin
                refresh_cnt <= refresh_cnt + CW'(1);
            end
        end
    end

    always_comb begin
        case (disp_sel)
            2'd0:    disp_src = result;
            2'd1:    disp_src = op_a;
            2'd2:    disp_src = op_b;
            default: disp_src = {{(WIDTH-4){1'b0}}, negative, zero, carryF, oVerflow};
        endcase
        nibble = disp_src[{digit_idx, 2'b00} +: 4];
        case (nibble)
            4'h0:    segments = 7'h40;
            4'h1:    segments = 7'h79;
            4'h2:    segments = 7'h24;
            4'h3:    segments = 7'h30;
            4'h4:    segments = 7'h19;
            4'h5:    segments = 7'h12;
            4'h6:    segments = 7'h02;
            4'h7:    segments = 7'h78;
            4'h8:    segments = 7'h00;
            4'h9:    segments = 7'h10;
            4'hA:    segments = 7'h08;
            4'hB:    segments = 7'h03;
            4'hC:    segments = 7'h46;
            4'hD:    segments = 7'h21;
            4'hE:    segments = 7'h06;
            default: segments = 7'h0E;
        endcase
        anodes = ~(DIGITS'(1) << digit_idx);
    end

endmodule

// File: tb/tb_alu_display_seq.sv
module tb_alu_display_seq;

    localparam int W  = 8;
    localparam int RD = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] a, b;
    logic [3:0]   sel;
    logic         start;
    logic [1:0]   disp_sel;
    logic [W-1:0] result;
    logic         negative, zero, carryF, oVerflow, valid;
    logic [6:0]   segments;
    logic [1:0]   anodes;

    alu_display_seq #(.WIDTH(W), .REFRESH_DIV(RD)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .sel(sel), .start(start),
        .disp_sel(disp_sel), .result(result), .negative(negative), .zero(zero),
        .carryF(carryF), .oVerflow(oVerflow), .valid(valid),
        .segments(segments), .anodes(anodes)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] res;
        logic [3:0] nzcv;
        int         due;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   ticks = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   chk_reset = 0, chk_disp = 0, chk_drain = 0;

    logic [7:0] mdl_a = '0, mdl_b = '0, mdl_res = '0;
    logic [3:0] mdl_nzcv = '0;

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // ticks = rising edges with rst_n high since the last reset edge
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        ticks <= rst_n ? ticks + 1 : 0;
    end

    // Reference ALU in plain integer arithmetic
    function automatic void ref_alu(input int ia, input int ib, input int is,
                                    output logic [7:0] r, output logic [3:0] nzcv);
        int s, sa, sb, sv, n;
        bit c, v;
        s = 0; c = 0; v = 0;
        sa = (ia >= 128) ? ia - 256 : ia;
        sb = (ib >= 128) ? ib - 256 : ib;
        n  = ib % 8;
        case (is)
            0: begin s = ia + ib; c = (s >= 256); sv = sa + sb; v = (sv > 127 || sv < -128); end
            1: begin s = ia + (255 - ib) + 1; c = (s >= 256); sv = sa - sb; v = (sv > 127 || sv < -128); end
            2: s = ia & ib;
            3: s = ia | ib;
            4: s = ia ^ ib;
            5: s = 255 - ia;
            6: begin s = ia << n; c = (n != 0) && (((ia >> (8 - n)) & 1) == 1); end
            7: begin s = ia >> n; c = (n != 0) && (((ia >> (n - 1)) & 1) == 1); end
            default: s = 0;
        endcase
        r = 8'(s & 255);
        nzcv = {r[7], (r == 8'h00), c, v};
    endfunction

    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic [3:0] is,
                         input bit expect_it);
        exp_t e;
        a = ia; b = ib; sel = is; start = 1'b1;
        mdl_a = ia; mdl_b = ib;
        if (expect_it) begin
            ref_alu(int'(ia), int'(ib), int'(is), e.res, e.nzcv);
            e.due = cyc + 2;
            q.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Monitor: sole owner of the comparison counters
    exp_t       m_e;
    logic [7:0] m_src;
    logic [3:0] m_nib;
    int         m_dg;

    always @(negedge clk) begin
        if (!rst_n) begin
            mdl_res  = '0;
            mdl_nzcv = '0;
        end else if (valid === 1'b1) begin
            if (q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL spurious_valid: valid=1 with no outstanding op at cycle %0d", cyc);
            end else begin
                m_e = q.pop_front();
                n_cmp++;
                if ({result, negative, zero, carryF, oVerflow} !== {m_e.res, m_e.nzcv}) begin
                    n_bad++;
                    $display("FAIL alu_out: got res=%h nzcv=%b, expected res=%h nzcv=%b",
                             result, {negative, zero, carryF, oVerflow}, m_e.res, m_e.nzcv);
                end
                n_cmp++;
                if (cyc != m_e.due) begin
                    n_bad++;
                    $display("FAIL latency: valid at cycle %0d, expected cycle %0d", cyc, m_e.due);
                end
                mdl_res  = m_e.res;
                mdl_nzcv = m_e.nzcv;
            end
        end else if (q.size() > 0 && q[0].due <= cyc) begin
            m_e = q.pop_front();
            n_cmp++; n_bad++;
            $display("FAIL missing_valid: valid=%b at cycle %0d, expected pulse with res=%h",
                     valid, cyc, m_e.res);
        end

        if (chk_reset) begin
            n_cmp++;
            if ({result, negative, zero, carryF, oVerflow, valid, anodes, segments}
                !== {8'h00, 4'b0000, 1'b0, 2'b10, 7'h40}) begin
                n_bad++;
                $display("FAIL reset_state: got res=%h nzcv=%b valid=%b an=%b seg=%h, expected res=00 nzcv=0000 valid=0 an=10 seg=40",
                         result, {negative, zero, carryF, oVerflow}, valid, anodes, segments);
            end
        end

        if (chk_disp) begin
            m_dg = (ticks / RD) % 2;
            case (disp_sel)
                2'd0:    m_src = mdl_res;
                2'd1:    m_src = mdl_a;
                2'd2:    m_src = mdl_b;
                default: m_src = {4'b0000, mdl_nzcv};
            endcase
            m_nib = (m_dg == 1) ? m_src[7:4] : m_src[3:0];
            n_cmp++;
            if ({anodes, segments} !== {((m_dg == 1) ? 2'b01 : 2'b10), glyph[m_nib]}) begin
                n_bad++;
                $display("FAIL display: disp_sel=%0d got an=%b seg=%h, expected an=%b seg=%h",
                         disp_sel, anodes, segments, ((m_dg == 1) ? 2'b01 : 2'b10), glyph[m_nib]);
            end
        end

        if (chk_drain) begin
            n_cmp++;
            if (q.size() != 0) begin
                n_bad++;
                $display("FAIL drain: %0d ops still pending, expected 0", q.size());
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; sel = '0; disp_sel = 2'd0;
        @(posedge clk); #1;
        chk_reset = 1;
        idle(2);
        chk_reset = 0;
        rst_n = 1'b1;

        issue(8'h7F, 8'h01, 4'd0, 1); idle(3);
        issue(8'hFF, 8'h01, 4'd0, 1);
        issue(8'h05, 8'h05, 4'd1, 1); idle(3);
        issue(8'h81, 8'h01, 4'd7, 1);
        issue(8'h5A, 8'h00, 4'd6, 1); idle(3);
        issue(8'h01, 8'h02, 4'd0, 1);
        issue(8'h01, 8'h02, 4'd1, 1); idle(3);

        // Display scan with result 0xA5, then every source
        issue(8'hA0, 8'h05, 4'd0, 1); idle(4);
        chk_disp = 1; disp_sel = 2'd0;
        idle(20);
        for (int ds = 1; ds < 4; ds++) begin
            disp_sel = 2'(ds);
            idle(5);
        end
        chk_disp = 0;

        // Flags N=1 Z=0 C=1 V=0 on digit 0
        issue(8'hFF, 8'hFF, 4'd0, 1); idle(4);
        chk_disp = 1; disp_sel = 2'd3;
        idle(10);
        disp_sel = 2'd0;
        idle(3);
        chk_disp = 0;

        repeat (200) begin
            issue(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)), 1);
            disp_sel = 2'($urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(4);

        // Reset right behind an accepted op; start during reset is ignored
        disp_sel = 2'd0;
        issue(8'h7F, 8'h01, 4'd0, 0);
        rst_n = 1'b0; start = 1'b1; a = 8'h11; b = 8'h22; sel = 4'd0;
        mdl_a = '0; mdl_b = '0;
        @(posedge clk); #1;
        chk_reset = 1;
        @(posedge clk); #1;
        start = 1'b0;
        idle(1);
        chk_reset = 0;
        rst_n = 1'b1;
        chk_disp = 1;
        idle(12);
        chk_disp = 0;

        issue(8'h03, 8'h04, 4'd0, 1); idle(4);

        chk_drain = 1;
        @(negedge clk); #1;
        chk_drain = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_display_seq.md
ALU_DISPLAY_SEQ -- requirements
Module: alu_display_seq

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width; SHALL be a multiple of 4 and at least 8.
REQ-002 Parameter: REFRESH_DIV, 50000, clock cycles each display digit stays lit; SHALL be at least 2.
REQ-003 Derived: DIGITS = WIDTH/4 hex digits; SW = log2(WIDTH) shift-amount bits.
REQ-004 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-006 Port: a  input  WIDTH  operand A.
REQ-007 Port: b  input  WIDTH  operand B.
REQ-008 Port: sel  input  4  operation select.
REQ-009 Port: start  input  1  capture a/b/sel this cycle.
REQ-010 Port: disp_sel  input  2  display source: 0 result, 1 captured A, 2 captured B, 3 flags.
REQ-011 Port: result  output  WIDTH  registered ALU result.
REQ-012 Port: negative, zero, carryF, oVerflow  output  1 each  registered flags N/Z/C/V.
REQ-013 Port: valid  output  1  one-cycle pulse when result/flags update.
REQ-014 Port: segments  output  7  active-low {g,f,e,d,c,b,a} of the lit digit.
REQ-015 Port: anodes  output  DIGITS  active-low digit enables, exactly one low.

Function
REQ-016 Stage 1: when start=1, SHALL register a, b, sel into op_a, op_b, op_sel and set s1_valid; else s1_valid=0, op regs hold.
REQ-017 Stage 2: when s1_valid=1, SHALL register result and flags from op regs and assert valid for exactly one cycle; otherwise result/flags hold.
REQ-018 Latency: start at edge t -> result/flags/valid visible after edge t+2; start accepted every cycle, back-to-back ops SHALL produce consecutive valid pulses.
REQ-019 sel 0000 ADD: a+b; C = carry out; V = signed overflow.
REQ-020 sel 0001 SUB: a+~b+1; C = carry out (1 = no borrow); V = signed overflow.
REQ-021 sel 0010 AND, 0011 OR, 0100 XOR, 0101 NOT a: C=0, V=0.
REQ-022 sel 0110 SHL, 0111 SHR logical: amount = b[SW-1:0]; C = last bit shifted out, 0 if amount=0; V=0.
REQ-023 sel 1000-1111: result 0, C=0, V=0.
REQ-024 All ops: N = result[WIDTH-1]; Z = (result == 0).
REQ-025 Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; on wrap, digit index SHALL advance, DIGITS-1 wraps to 0.
REQ-026 anodes SHALL drive bit[digit index] low, others high; segments SHALL show nibble[digit index] of selected source (combinational from registers, no extra latency).
REQ-027 disp_sel=3: digit 0 nibble = {N,Z,C,V}; higher digits show 0.
REQ-028 Glyphs: standard hex 0-F active-low; e.g. 0=0x40, 5=0x12, 8=0x00, A=0x08, F=0x0E.
REQ-029 disp_sel change SHALL take effect same cycle without resetting scan position.

Reset
REQ-030 rst_n=0 at an edge SHALL clear op regs, s1_valid, result, all flags, valid, refresh counter and digit index.
REQ-031 After reset: anodes = all high except bit 0 low, segments = 0x40.
REQ-032 Reset mid-operation SHALL discard in-flight op; no valid pulse for it; start sampled while rst_n=0 ignored.

Verification (WIDTH=8)
REQ-033 ADD a=0x7F b=0x01 -> at t+2 result=0x80, N=1 Z=0 C=0 V=1, valid=1 one cycle.
REQ-034 ADD a=0xFF b=0x01 -> result=0x00, Z=1 C=1 V=0 N=0; SUB a=0x05 b=0x05 -> 0x00, Z=1 C=1 V=0.
REQ-035 SHR a=0x81 b=0x01 -> result=0x40, C=1; SHL b=0x00 -> result=a, C=0.
REQ-036 Back-to-back: start on two edges (ADD 1+2, SUB 1+2... SUB 1-2) -> valid on two consecutive cycles, results 0x03 then 0xFF (C=0, N=1).
REQ-037 REFRESH_DIV=4, result=0xA5, disp_sel=0 -> anodes=10 segments=0x12 for 4 cycles, then anodes=01 segments=0x08 for 4, repeat; disp_sel=3 with N=1 Z=0 C=1 V=0 -> digit 0 glyph A.
REQ-038 start at t, rst_n=0 at t+1 -> valid never asserts, result=0x00, anodes=10, segments=0x40.
